// File: rtl/serial_pkg.sv
// Shared constants and state encoding for the serial receiver.
package serial_pkg;

    localparam int unsigned CLKS_PER_BIT_DEF = 16;
    localparam int unsigned DATA_BITS_DEF    = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/serial_rx_sync2.sv
// Two-flop synchronizer with asynchronous active-low reset to a chosen value.
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/serial_rx.sv
// UART-style serial receiver: start-bit validation, centre sampling, stop-bit check.
module serial_rx
    import serial_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned DATA_BITS    = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT) + 1;
    localparam int unsigned BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BITS_LAST = BW'(DATA_BITS - 1);

    logic rx_s;

    sync2 #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (in),
        .q    (rx_s)
    );

    rx_state_e state_q, state_d;
    logic [CW-1:0]        cnt_q;
    logic [BW-1:0]        bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 frame_err_q;
    logic                 hold_q;

    logic cnt_clr;
    logic shift_en;
    logic load;
    logic err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_clr  = 1'b0;
        shift_en = 1'b0;
        load     = 1'b0;
        err      = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_clr = 1'b1;
                // After a frame error the line must go high before a new start counts.
                if (!rx_s && !hold_q) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_clr = 1'b1;
                    state_d = rx_s ? StIdle : StData;
                end
            end
            StData: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_q == BITS_LAST) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_clr = 1'b1;
                    state_d = StIdle;
                    load    = rx_s;
                    err     = ~rx_s;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            bit_q <= '0;
        end else begin
            cnt_q <= cnt_clr ? '0 : cnt_q + CW'(1);
            if (state_q == StIdle) begin
                bit_q <= '0;
            end else if (shift_en) begin
                bit_q <= bit_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            hold_q      <= 1'b0;
        end else begin
            if (shift_en) begin
                shift_q[bit_q] <= rx_s;
            end
            if (load) begin
                data_q <= shift_q;
            end
            valid_q     <= load;
            frame_err_q <= err;
            if (err) begin
                hold_q <= 1'b1;
            end else if (rx_s) begin
                hold_q <= 1'b0;
            end
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_serial_rx.sv
// Randomized self-checking bench for serial_rx with a frame-level scoreboard.
`timescale 1ns/1ps
module tb_serial_rx;

    localparam int unsigned CA = 16;
    localparam int unsigned DA = 8;
    localparam int unsigned CB = 5;
    localparam int unsigned DB = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_a = 1'b1;
    logic in_b = 1'b1;

    logic [DA-1:0] data_a;
    logic          valid_a, ferr_a, busy_a;
    logic [DB-1:0] data_b;
    logic          valid_b, ferr_b, busy_b;

    always #5 clk = ~clk;

    serial_rx dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (in_a),
        .data     (data_a),
        .valid    (valid_a),
        .frame_err(ferr_a),
        .busy     (busy_a)
    );

    serial_rx #(
        .CLKS_PER_BIT(CB),
        .DATA_BITS   (DB)
    ) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (in_b),
        .data     (data_b),
        .valid    (valid_b),
        .frame_err(ferr_b),
        .busy     (busy_b)
    );

    typedef struct {
        logic [7:0] val;
        bit         err;
        int         t;
    } exp_t;

    exp_t       sb_a[$];
    exp_t       sb_b[$];
    logic [7:0] model_a = '0;
    logic [7:0] model_b = '0;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int pulses_a = 0;
    int fall_b = 0;
    int last_valid_b = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame-level reference: each full frame sent predicts one pulse of a known kind,
    // payload and cycle; between pulses the payload output must hold the last good frame.
    task automatic scan(input int which, input logic v, input logic fe, input logic [7:0] d);
        exp_t e;
        bit   have;
        chk(which == 0 ? "exclusive_a" : "exclusive_b", {31'd0, v & fe}, 32'd0);
        have = (which == 0) ? (sb_a.size() > 0) : (sb_b.size() > 0);
        if (have) begin
            e = (which == 0) ? sb_a[0] : sb_b[0];
            if (cyc > e.t + 1) begin
                checks++;
                errors++;
                $display("FAIL missed_pulse_%0d: none by cycle %0d, expected at %0d", which, cyc, e.t);
                if (which == 0) void'(sb_a.pop_front()); else void'(sb_b.pop_front());
                have = 1'b0;
            end
        end
        if (v || fe) begin
            if (!have) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse_%0d: valid=%0b frame_err=%0b, expected none",
                         which, v, fe);
            end else begin
                if (which == 0) begin
                    e = sb_a.pop_front();
                    pulses_a++;
                end else begin
                    e = sb_b.pop_front();
                    if (v) last_valid_b = cyc;
                end
                chk("pulse_kind", {30'd0, v, fe}, e.err ? 32'd1 : 32'd2);
                checks++;
                if (cyc < e.t - 1 || cyc > e.t + 1) begin
                    errors++;
                    $display("FAIL pulse_latency_%0d: got cycle %0d, expected %0d +-1",
                             which, cyc, e.t);
                end
                if (!e.err) begin
                    if (which == 0) model_a = e.val; else model_b = e.val;
                end
            end
        end
        chk(which == 0 ? "data_a" : "data_b", {24'd0, d}, {24'd0, which == 0 ? model_a : model_b});
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            sb_a.delete();
            sb_b.delete();
            model_a = '0;
            model_b = '0;
            chk("reset_a", {21'd0, data_a, valid_a, ferr_a, busy_a}, 32'd0);
            chk("reset_b", {22'd0, data_b, valid_b, ferr_b, busy_b}, 32'd0);
        end else begin
            scan(0, valid_a, ferr_a, data_a);
            scan(1, valid_b, ferr_b, {1'b0, data_b});
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_line(input int which, input logic b);
        if (which == 0) in_a = b; else in_b = b;
    endtask

    // abort_bit >= 0 stops mid data bit; low_tail extends a low stop bit.
    task automatic send(input int which, input logic [7:0] val, input bit stop_ok,
                        input int abort_bit, input int low_tail);
        int   c;
        int   d;
        exp_t e;
        c = (which == 0) ? CA : CB;
        d = (which == 0) ? DA : DB;
        set_line(which, 1'b0);
        if (abort_bit < 0) begin
            e.val = (which == 0) ? val : {1'b0, val[6:0]};
            e.err = !stop_ok;
            e.t   = cyc + 3 + c / 2 + (d + 1) * c;
            if (which == 0) sb_a.push_back(e); else sb_b.push_back(e);
        end
        if (which == 1) fall_b = cyc;
        wait_cyc(c);
        for (int i = 0; i < d; i++) begin
            set_line(which, val[i]);
            if (i == abort_bit) begin
                wait_cyc(c / 2);
                return;
            end
            wait_cyc(c);
            if (i == 2 && abort_bit < 0)
                chk("busy_mid_frame", {31'd0, which == 0 ? busy_a : busy_b}, 32'd1);
        end
        set_line(which, stop_ok);
        wait_cyc(c + (stop_ok ? 0 : low_tail));
        set_line(which, 1'b1);
    endtask

    initial begin
        bit saw;
        int p0;
        logic [7:0] v;
        bit ok;
        wait_cyc(4);
        rst_n = 1'b1;
        wait_cyc(2 * CA);
        chk("idle_busy", {31'd0, busy_a}, 32'd0);

        send(0, 8'hA5, 1'b1, -1, 0);
        wait_cyc(CA);
        chk("a5_data", {24'd0, data_a}, 32'hA5);

        send(0, 8'h3C, 1'b0, -1, 0);
        wait_cyc(CA);
        chk("err_keeps_data", {24'd0, data_a}, 32'hA5);
        send(0, 8'h01, 1'b1, -1, 0);
        wait_cyc(CA);
        chk("after_err_data", {24'd0, data_a}, 32'h01);

        // Stop bit low and line held low for a while: one frame_err only.
        send(0, 8'h99, 1'b0, -1, 3 * CA);
        wait_cyc(2 * CA);
        chk("held_low_idle", {31'd0, busy_a}, 32'd0);

        set_line(0, 1'b0);
        wait_cyc(2);
        set_line(0, 1'b1);
        saw = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (busy_a) saw = 1'b1;
        end
        chk("glitch_busy", {31'd0, saw}, 32'd1);
        wait_cyc(CA);
        chk("glitch_idle", {31'd0, busy_a}, 32'd0);

        p0 = pulses_a;
        send(0, 8'h00, 1'b1, -1, 0);
        send(0, 8'hFF, 1'b1, -1, 0);
        send(0, 8'h55, 1'b1, -1, 0);
        wait_cyc(CA);
        chk("b2b_count", pulses_a - p0, 32'd3);
        chk("b2b_last", {24'd0, data_a}, 32'h55);

        send(0, 8'h81, 1'b1, 3, 0);
        rst_n = 1'b0;
        set_line(0, 1'b1);
        #1;
        chk("reset_now", {21'd0, data_a, valid_a, ferr_a, busy_a}, 32'd0);
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(2 * CA);
        send(0, 8'h7E, 1'b1, -1, 0);
        wait_cyc(CA);
        chk("post_reset_data", {24'd0, data_a}, 32'h7E);

        send(1, 8'h5A, 1'b1, -1, 0);
        wait_cyc(3 * CB);
        chk("small_data", {25'd0, data_b}, 32'h5A);
        checks++;
        if (last_valid_b - fall_b < 44 || last_valid_b - fall_b > 46) begin
            errors++;
            $display("FAIL small_latency: got %0d cycles, expected 45 +-1", last_valid_b - fall_b);
        end

        for (int k = 0; k < 10; k++) begin
            v  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 3) != 0);
            send(0, v, ok, -1, 0);
            wait_cyc(ok ? $urandom_range(0, CA) : CA + $urandom_range(0, CA));
        end
        wait_cyc(3 * CA);
        chk("scoreboard_drained", sb_a.size() + sb_b.size(), 32'd0);
        chk("final_busy", {31'd0, busy_a}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
